// File: rtl/store_write_buffer.sv
`timescale 1ns/1ps
// In-order store write buffer between the core's M-stage store port and data memory.
// Stores retire into a small FIFO, drain to memory one per ack, and loads hitting a pending word are flagged.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [DW/8-1:0]          st_be,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_conflict,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW/8-1:0]          mem_be,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int BW = DW / 8;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]    wrPtr_r;
  logic [PW-1:0]    rdPtr_r;
  logic [AW-1:0]    addrMem_r [DEPTH];
  logic [DW-1:0]    dataMem_r [DEPTH];
  logic [BW-1:0]    beMem_r   [DEPTH];
  logic [DEPTH-1:0] valid_r;

  logic [IW-1:0]    wrIdx_s;
  logic [IW-1:0]    rdIdx_s;
  logic             full_s;
  logic             empty_s;
  logic             enq_s;
  logic             deq_s;
  logic [DEPTH-1:0] setMask_s;
  logic [DEPTH-1:0] clrMask_s;
  logic             pendHit_s;
  logic             inHit_s;
  logic [3:0]       unusedAddrBits_s;

  assign wrIdx_s  = wrPtr_r[IW-1:0];
  assign rdIdx_s  = rdPtr_r[IW-1:0];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s  = (wrPtr_r == rdPtr_r);
  assign full_s   = (wrPtr_r[IW] != rdPtr_r[IW]) && (wrIdx_s == rdIdx_s);
  assign st_ready = !full_s;
  assign enq_s    = st_valid && !full_s;
  assign deq_s    = !empty_s && mem_ack;
  assign count    = wrPtr_r - rdPtr_r;

  // Byte offsets never take part in the word-granular hazard compare.
  assign unusedAddrBits_s = {ld_addr[1:0], st_addr[1:0]};

  // Write and read pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
    end else begin
      if (enq_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (deq_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
    end
  end

  // Entry payload storage, written at the tail slot on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addrMem_r[i] <= {AW{1'b0}};
        dataMem_r[i] <= {DW{1'b0}};
        beMem_r[i]   <= {BW{1'b0}};
      end
    end else if (enq_s) begin
      addrMem_r[wrIdx_s] <= st_addr;
      dataMem_r[wrIdx_s] <= st_data;
      beMem_r[wrIdx_s]   <= st_be;
    end
  end

  // One-hot set/clear masks for the per-entry valid bits.
  always_comb begin
    setMask_s = {DEPTH{1'b0}};
    clrMask_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      setMask_s[i] = enq_s && (wrIdx_s == IW'(i));
      clrMask_s[i] = deq_s && (rdIdx_s == IW'(i));
    end
  end

  // Entry valid bits; a full buffer never enqueues, so set and clear never hit the same slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      valid_r <= (valid_r | setMask_s) & ~clrMask_s;
    end
  end

  // Load hazard: word match against any pending entry or the store arriving this cycle.
  always_comb begin
    pendHit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pendHit_s = pendHit_s |
                  (valid_r[i] && (addrMem_r[i][AW-1:2] == ld_addr[AW-1:2]));
    end
    inHit_s     = st_valid && (st_addr[AW-1:2] == ld_addr[AW-1:2]);
    ld_conflict = ld_valid && (pendHit_s || inHit_s);
  end

  // Memory-side head presentation, driven only from registered state.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    mem_be    = {BW{1'b0}};
    if (!empty_s) begin
      mem_we    = 1'b1;
      mem_addr  = addrMem_r[rdIdx_s];
      mem_wdata = dataMem_r[rdIdx_s];
      mem_be    = beMem_r[rdIdx_s];
    end else begin
      mem_we    = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for store_write_buffer: a cycle model pushes expected memory writes,
// a negedge monitor pops and compares whenever the buffer writes memory.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic [3:0]  st_be = 4'd0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic        ld_conflict;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [2:0]  count;

  st_t sbq[$];
  int  mcount = 0;
  int  compared = 0;
  int  mismatched = 0;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: accepted stores are pushed as expected memory writes.
  always @(posedge clk or negedge reset) begin
    st_t e;
    bit acc, deq;
    if (!reset) begin
      sbq.delete();
      mcount = 0;
    end else begin
      acc = st_valid && (mcount < DEPTH);
      deq = (mcount > 0) && mem_ack;
      if (acc) begin
        e.a = st_addr; e.d = st_data; e.be = st_be;
        sbq.push_back(e);
      end
      mcount = mcount + int'(acc) - int'(deq);
    end
  end

  // Monitor: checks state every cycle and pops the scoreboard on each memory write.
  always @(negedge clk) begin
    st_t e;
    chk("count", 32'(count), 32'(mcount));
    chk("st_ready", 32'(st_ready), 32'(mcount < DEPTH));
    chk("mem_we", 32'(mem_we), 32'(mcount > 0));
    if (mem_we && mem_ack) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0h expected none (t=%0t)", mem_addr, $time);
      end else begin
        e = sbq.pop_front();
        chk("mem_addr", mem_addr, e.a);
        chk("mem_wdata", mem_wdata, e.d);
        chk("mem_be", 32'(mem_be), 32'(e.be));
      end
    end else if (!mem_we) begin
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_be", 32'(mem_be), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setSt(input logic v, input logic [31:0] a, input logic [3:0] be);
    st_valid = v;
    st_addr  = a;
    st_data  = {a[15:0], 16'hC0DE};
    st_be    = be;
  endtask

  initial begin
    int sent;
    // Reset state
    repeat (2) step();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    reset = 1'b1;
    step();

    // 1: fill with mem_ack low, fifth store refused
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setSt(1'b1, 32'(100 + 4 * i), 4'hF);
      step();
    end
    chk("t1_st_ready", 32'(st_ready), 32'd0);
    chk("t1_count", 32'(count), 32'd4);
    setSt(1'b1, 32'd116, 4'hF);
    step();
    chk("t1_count_hold", 32'(count), 32'd4);
    setSt(1'b0, 32'd0, 4'h0);

    // 2: drain in order
    mem_ack = 1'b1;
    repeat (4) step();
    mem_ack = 1'b0;
    chk("t2_mem_we", 32'(mem_we), 32'd0);
    chk("t2_count", 32'(count), 32'd0);

    // 3: concurrent enqueue/dequeue at count 2
    setSt(1'b1, 32'd200, 4'hF); step();
    setSt(1'b1, 32'd204, 4'hF); step();
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setSt(1'b1, 32'(208 + 4 * i), 4'hF);
      step();
    end
    chk("t3_count", 32'(count), 32'd2);
    setSt(1'b0, 32'd0, 4'h0);
    repeat (2) step();
    mem_ack = 1'b0;

    // 4: full with simultaneous ack
    for (int i = 0; i < 4; i++) begin
      setSt(1'b1, 32'(300 + 4 * i), 4'hF);
      step();
    end
    setSt(1'b1, 32'd316, 4'hF);
    mem_ack = 1'b1;
    step();
    setSt(1'b0, 32'd0, 4'h0);
    mem_ack = 1'b0;
    chk("t4_count", 32'(count), 32'd3);
    chk("t4_st_ready", 32'(st_ready), 32'd1);
    mem_ack = 1'b1;
    repeat (3) step();
    mem_ack = 1'b0;

    // 5: load hazard with sb to 99 pending
    setSt(1'b1, 32'd99, 4'b1000);
    step();
    setSt(1'b0, 32'd0, 4'h0);
    ld_addr = 32'd96; #1;
    chk("t5_ld_invalid", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b1; #1;
    chk("t5_ld96", 32'(ld_conflict), 32'd1);
    ld_addr = 32'd98; #1;
    chk("t5_ld98", 32'(ld_conflict), 32'd1);
    ld_addr = 32'd100; #1;
    chk("t5_ld100", 32'(ld_conflict), 32'd0);
    ld_addr = 32'd104;
    setSt(1'b1, 32'd107, 4'b1000); #1;
    chk("t5_ld104_incoming", 32'(ld_conflict), 32'd1);
    step();
    setSt(1'b0, 32'd0, 4'h0);
    ld_valid = 1'b0;
    mem_ack = 1'b1;
    repeat (2) step();

    // 6: ten stores with random ack across the pointer wrap
    sent = 0;
    for (int it = 0; it < 200 && sent < 10; it++) begin
      setSt(1'b1, 32'(400 + 4 * sent), 4'hF);
      mem_ack = 1'($urandom_range(0, 1));
      if (mcount < DEPTH) sent++;
      step();
    end
    chk("t6_issued", 32'(sent), 32'd10);
    setSt(1'b0, 32'd0, 4'h0);
    mem_ack = 1'b1;
    for (int it = 0; it < 20 && mcount > 0; it++) step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setSt(1'b1, 32'(500 + 4 * i), 4'hF);
      step();
    end
    setSt(1'b0, 32'd0, 4'h0);
    chk("t6_count_pre", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_mem_we", 32'(mem_we), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_st_ready", 32'(st_ready), 32'd1);
    mem_ack = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    mem_ack = 1'b0;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
